// File: rtl/ace_ar_rr_arbiter.sv
// Round-robin merge of NoMasters ACE AR channels into one registered AR channel,
// with the master index prepended to the ID and combinational R routing back by that index.
module ace_ar_rr_arbiter #(
  parameter int unsigned NoMasters      = 2,
  parameter int unsigned IdWidthIn      = 4,
  parameter int unsigned ArPayloadWidth = 100,
  parameter int unsigned RPayloadWidth  = 70,
  parameter int unsigned MaxTrans       = 8,
  localparam int unsigned IdxW       = $clog2(NoMasters),
  localparam int unsigned IdWidthOut = IdWidthIn + IdxW,
  localparam int unsigned CntW       = $clog2(MaxTrans + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NoMasters-1:0]                     slv_ar_valid_i,
  output logic [NoMasters-1:0]                     slv_ar_ready_o,
  input  logic [NoMasters-1:0][IdWidthIn-1:0]      slv_ar_id_i,
  input  logic [NoMasters-1:0][ArPayloadWidth-1:0] slv_ar_payload_i,
  output logic                                     mst_ar_valid_o,
  input  logic                                     mst_ar_ready_i,
  output logic [IdWidthOut-1:0]                    mst_ar_id_o,
  output logic [ArPayloadWidth-1:0]                mst_ar_payload_o,
  input  logic                                     mst_r_valid_i,
  output logic                                     mst_r_ready_o,
  input  logic [IdWidthOut-1:0]                    mst_r_id_i,
  input  logic                                     mst_r_last_i,
  input  logic [RPayloadWidth-1:0]                 mst_r_payload_i,
  output logic [NoMasters-1:0]                     slv_r_valid_o,
  input  logic [NoMasters-1:0]                     slv_r_ready_i,
  output logic [IdWidthIn-1:0]                     slv_r_id_o,
  output logic                                     slv_r_last_o,
  output logic [RPayloadWidth-1:0]                 slv_r_payload_o,
  output logic                                     r_decerr_o
);

  // Handshakes: a beat transfers on a rising clock edge where valid and ready are both high;
  // a valid source holds its beat stable until that edge.
  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e                             state_q, state_d;
  logic [IdxW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [NoMasters-1:0][CntW-1:0]     cnt_q, cnt_d;
  logic [IdWidthOut-1:0]              ar_id_q, ar_id_d;
  logic [ArPayloadWidth-1:0]          ar_payload_q, ar_payload_d;
  logic                               r_decerr_q, r_decerr_d;

  logic [NoMasters-1:0] eligible;
  logic                 gnt_found;
  logic [IdxW-1:0]      gnt_idx;
  logic [IdxW-1:0]      cand;
  logic                 ar_grant;
  logic [IdxW-1:0]      r_idx;
  logic                 r_idx_ok;
  logic                 r_retire;

  always_comb begin
    for (int i = 0; i < int'(NoMasters); i++) begin
      eligible[i] = slv_ar_valid_i[i] && (cnt_q[i] < CntW'(MaxTrans));
    end
  end

  // First eligible master at or after rr_ptr, wrapping at NoMasters.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NoMasters); k++) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(NoMasters));
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    ar_id_d        = ar_id_q;
    ar_payload_d   = ar_payload_q;
    slv_ar_ready_o = '0;
    ar_grant       = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (gnt_found && !rst_i) begin
          slv_ar_ready_o[gnt_idx] = 1'b1;
          ar_grant                = 1'b1;
          state_d                 = ST_FULL;
          rr_ptr_d                = (gnt_idx == IdxW'(NoMasters - 1)) ? '0 : gnt_idx + 1'b1;
          ar_id_d                 = {gnt_idx, slv_ar_id_i[gnt_idx]};
          ar_payload_d            = slv_ar_payload_i[gnt_idx];
        end
      end
      ST_FULL: begin
        if (mst_ar_ready_i) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign r_idx    = mst_r_id_i[IdWidthOut-1 -: IdxW];
  assign r_idx_ok = (32'(r_idx) < NoMasters);

  // Beats with an unknown index are swallowed so the downstream port never stalls on them.
  always_comb begin
    slv_r_valid_o = '0;
    mst_r_ready_o = 1'b1;
    if (r_idx_ok) begin
      slv_r_valid_o[r_idx] = mst_r_valid_i;
      mst_r_ready_o        = slv_r_ready_i[r_idx];
    end
  end

  assign r_retire   = mst_r_valid_i && mst_r_ready_o && mst_r_last_i && r_idx_ok;
  assign r_decerr_d = mst_r_valid_i && !r_idx_ok;

  always_comb begin
    for (int i = 0; i < int'(NoMasters); i++) begin
      cnt_d[i] = cnt_q[i];
      if ((ar_grant && gnt_idx == IdxW'(i)) && !(r_retire && r_idx == IdxW'(i))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!(ar_grant && gnt_idx == IdxW'(i)) && (r_retire && r_idx == IdxW'(i))) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      ar_id_q      <= '0;
      ar_payload_q <= '0;
      r_decerr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      ar_id_q      <= ar_id_d;
      ar_payload_q <= ar_payload_d;
      r_decerr_q   <= r_decerr_d;
    end
  end

  assign mst_ar_valid_o   = (state_q == ST_FULL);
  assign mst_ar_id_o      = ar_id_q;
  assign mst_ar_payload_o = ar_payload_q;
  assign slv_r_id_o       = mst_r_id_i[IdWidthIn-1:0];
  assign slv_r_last_o     = mst_r_last_i;
  assign slv_r_payload_o  = mst_r_payload_i;
  assign r_decerr_o       = r_decerr_q;

  // Retiring a read for a master with nothing outstanding means the downstream side is out of sync.
  for (genvar gi = 0; gi < int'(NoMasters); gi++) begin : g_cnt_chk
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(r_retire && r_idx == IdxW'(gi) && cnt_q[gi] == '0));
  end

endmodule
